// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the multi-cycle RV32I core.
// Contents: opcode and funct3 codes, the controller state enum, the ALU
// operation enum, and helpers that build sign-extended immediates from an
// instruction word.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: x1..x31 general-purpose registers; x0 is hard-wired zero.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears x1..x31)
//   rs1_addr_i/rs2_addr_i, rs1_data_o/rs2_data_o   two asynchronous read ports
//   we_i, rd_addr_i, rd_data_i                      one synchronous write port
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i
);

  logic [31:0] regs_q [1:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/rv32i_cpu.sv
// rv32i_cpu: multi-cycle RV32I core, sole master of a word-wide memory port.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   memory_out      combinational read data for the current address
//   memory_in       write data (0 whenever write_enable is low)
//   address         word address (byte address = {address, 2'b00})
//   write_enable    commit memory_in at address on this clock edge
//   read_capable    memory reports the current address readable
//   write_capable   memory reports the current address writable
//
// state | meaning
// FETCH | two cycles: present pc, then latch the instruction word
// EXEC  | decode, ALU, register write, pc update
// MEM   | load/store access at the effective address
// HALT  | terminal fault/stop state, left only by reset
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_in,
  output logic [29:0] address,
  output logic        write_enable,
  input  logic        read_capable,
  input  logic        write_capable
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        fetch_ph_q, fetch_ph_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        rd_we;
  logic [31:0] rd_wdata;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];

  rv32i_regfile u_rf (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (ir_q[19:15]),
    .rs2_addr_i (ir_q[24:20]),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .we_i       (rd_we),
    .rd_addr_i  (ir_q[11:7]),
    .rd_data_i  (rd_wdata)
  );

  // Effective address and access legality
  logic [31:0] ea;
  logic        mem_fault;
  assign ea = rs1_val + ((opcode == OP_STORE) ? imm_s(ir_q) : imm_i(ir_q));

  always_comb begin
    mem_fault = 1'b0;
    unique case (funct3[1:0])
      2'd1:    mem_fault = ea[0];
      2'd2:    mem_fault = (ea[1:0] != 2'b00);
      2'd3:    mem_fault = 1'b1;
      default: mem_fault = 1'b0;
    endcase
    // Only LBU/LHU use funct3[2]; stores have no unsigned forms.
    if (funct3[2] && ((opcode == OP_STORE) || (funct3[1:0] != 2'd0 && funct3[1:0] != 2'd1)))
      mem_fault = 1'b1;
  end

  // ALU
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res;
  assign alu_b = (opcode == OP_OP) ? rs2_val : imm_i(ir_q);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      F3_ADD:  alu_op = ((opcode == OP_OP) && ir_q[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = ir_q[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_val + alu_b;
      ALU_SUB:  alu_res = rs1_val - alu_b;
      ALU_SLL:  alu_res = rs1_val << alu_b[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, rs1_val < alu_b};
      ALU_XOR:  alu_res = rs1_val ^ alu_b;
      ALU_SRL:  alu_res = rs1_val >> alu_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
      ALU_OR:   alu_res = rs1_val | alu_b;
      default:  alu_res = rs1_val & alu_b;
    endcase
  end

  // Branch condition
  logic br_take;
  always_comb begin
    br_take = 1'b0;
    case (funct3)
      F3_BEQ:  br_take = (rs1_val == rs2_val);
      F3_BNE:  br_take = (rs1_val != rs2_val);
      F3_BLT:  br_take = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_take = (rs1_val < rs2_val);
      F3_BGEU: br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Load lane extraction and store read-modify-write merge
  logic [31:0] load_shift, load_val, store_word;
  assign load_shift = memory_out >> {ea[1:0], 3'b000};

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_LB:   load_val = {{24{load_shift[7]}}, load_shift[7:0]};
      F3_LH:   load_val = {{16{load_shift[15]}}, load_shift[15:0]};
      F3_LW:   load_val = memory_out;
      F3_LBU:  load_val = {24'd0, load_shift[7:0]};
      F3_LHU:  load_val = {16'd0, load_shift[15:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    store_word = memory_out;
    case (funct3)
      F3_SB:   store_word[{ea[1:0], 3'b000} +: 8]  = rs2_val[7:0];
      F3_SH:   store_word[{ea[1], 4'b0000} +: 16]  = rs2_val[15:0];
      default: store_word = rs2_val;
    endcase
  end

  // Memory port; write_enable is purely combinational from state_q so an
  // asynchronous reset withdraws it immediately.
  assign write_enable = (state_q == MEM) && (opcode == OP_STORE) && !mem_fault && write_capable;
  assign memory_in    = write_enable ? store_word : 32'h0;
  assign address      = (state_q == MEM) ? ea[31:2] : pc_q[31:2];

  // Controller
  logic [31:0] jump_tgt;
  always_comb begin
    jump_tgt = pc_q + imm_j(ir_q);
    if (opcode == OP_JALR) jump_tgt = (rs1_val + imm_i(ir_q)) & ~32'd1;
    else if (opcode == OP_BRANCH) jump_tgt = pc_q + imm_b(ir_q);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    fetch_ph_d = fetch_ph_q;
    rd_we      = 1'b0;
    rd_wdata   = '0;
    case (state_q)
      FETCH: begin
        // First cycle only presents pc; the word is captured on the second edge.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          if (!read_capable) begin
            state_d = HALT;
          end else begin
            ir_d    = memory_out;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + 32'd4;
        case (opcode)
          OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u(ir_q); end
          OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u(ir_q); end
          OP_IMM, OP_OP: begin rd_we = 1'b1; rd_wdata = alu_res; end
          OP_FENCE: ;
          OP_JAL, OP_JALR: begin
            if (jump_tgt[1:0] != 2'b00) begin
              state_d = HALT;
              pc_d    = pc_q;
            end else begin
              rd_we    = 1'b1;
              rd_wdata = pc_q + 32'd4;
              pc_d     = jump_tgt;
            end
          end
          OP_BRANCH: begin
            if (br_take) begin
              if (jump_tgt[1:0] != 2'b00) begin
                state_d = HALT;
                pc_d    = pc_q;
              end else begin
                pc_d = jump_tgt;
              end
            end
          end
          OP_LOAD, OP_STORE: begin
            state_d = MEM;
            pc_d    = pc_q;
          end
          default: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
        endcase
      end
      MEM: begin
        if (mem_fault || ((opcode == OP_LOAD) ? !read_capable : !write_capable)) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          pc_d    = pc_q + 32'd4;
          if (opcode == OP_LOAD) begin
            rd_we    = 1'b1;
            rd_wdata = load_val;
          end
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      fetch_ph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      fetch_ph_q <= fetch_ph_d;
    end
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
module tb_rv32i_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] memory_out, memory_in;
  logic [29:0] address;
  logic        write_enable, read_capable, write_capable;

  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic        clr_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_dat = '0;
  logic        wcap_en = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          we_cnt = 0;
  int          we0;

  rv32i_cpu dut (
    .clk           (clk),
    .rst           (rst),
    .memory_out    (memory_out),
    .memory_in     (memory_in),
    .address       (address),
    .write_enable  (write_enable),
    .read_capable  (read_capable),
    .write_capable (write_capable)
  );

  always #5 clk = ~clk;

  assign memory_out    = mem[address[7:0]];
  assign read_capable  = (address[29:8] == 22'd0);
  assign write_capable = wcap_en;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_dat;
    end else if (write_enable) begin
      mem[address[7:0]] <= memory_in;
    end
  end

  always @(negedge clk) if (write_enable) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    ld_idx = idx[7:0];
    ld_dat = d;
    ld_en  = 1'b1;
    @(posedge clk); #1;
    ld_en  = 1'b0;
  endtask

  task automatic reset_clear();
    rst = 1'b0;
    clr_en = 1'b1;
    @(posedge clk); #1;
    clr_en = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset and two ADDIs
    reset_clear();
    clocks(2);
    chk("rst_addr", {2'b00, address}, 32'h0);
    chk("rst_we", {31'd0, write_enable}, 32'h0);
    poke(0, 32'h00500093);
    poke(1, 32'hfff08113);
    poke(2, 32'h00100073);
    release_rst();
    chk("first_fetch", {2'b00, address}, 32'h0);
    clocks(6);
    chk("addi_x1", dut.u_rf.regs_q[1], 32'd5);
    chk("addi_x2", dut.u_rf.regs_q[2], 32'd4);
    chk("addi_pc", dut.pc_q, 32'h8);

    // Sub-word store then loads
    reset_clear();
    poke(64, 32'hAABBCCDD);
    poke(0, 32'h10000093);
    poke(1, 32'h01100113);
    poke(2, 32'h002080A3);
    poke(3, 32'h00108183);
    poke(4, 32'h0030C203);
    poke(5, 32'h00308283);
    poke(6, 32'h00100073);
    we0 = we_cnt;
    release_rst();
    clocks(40);
    chk("sb_word", mem[64], 32'hAABB11DD);
    chk("sb_we_once", we_cnt - we0, 32'd1);
    chk("lb_b1", dut.u_rf.regs_q[3], 32'h00000011);
    chk("lbu_b3", dut.u_rf.regs_q[4], 32'h000000AA);
    chk("lb_b3", dut.u_rf.regs_q[5], 32'hFFFFFFAA);
    chk("ld_halt_addr", {2'b00, address}, 32'd6);

    // ALU operations
    reset_clear();
    poke(0, 32'hFF800093);
    poke(1, 32'h00300113);
    poke(2, 32'h4020D1B3);
    poke(3, 32'h0020D233);
    poke(4, 32'h0020A2B3);
    poke(5, 32'h0020B333);
    poke(6, 32'h401103B3);
    poke(7, 32'h00411413);
    poke(8, 32'h123454B7);
    poke(9, 32'h00001517);
    poke(10, 32'h00700013);
    poke(11, 32'h000005B3);
    poke(12, 32'h00100073);
    release_rst();
    clocks(48);
    chk("sra", dut.u_rf.regs_q[3], 32'hFFFFFFFF);
    chk("srl", dut.u_rf.regs_q[4], 32'h1FFFFFFF);
    chk("slt", dut.u_rf.regs_q[5], 32'd1);
    chk("sltu", dut.u_rf.regs_q[6], 32'd0);
    chk("sub", dut.u_rf.regs_q[7], 32'd11);
    chk("slli", dut.u_rf.regs_q[8], 32'd48);
    chk("lui", dut.u_rf.regs_q[9], 32'h12345000);
    chk("auipc", dut.u_rf.regs_q[10], 32'h00001024);
    chk("x0_zero", dut.u_rf.regs_q[11], 32'd0);
    chk("alu_halt_addr", {2'b00, address}, 32'd12);

    // Branches and jumps
    reset_clear();
    poke(0, 32'h0100006F);
    poke(4, 32'h00000463);
    poke(5, 32'h00100073);
    poke(6, 32'h00001463);
    poke(7, 32'h00128293);
    poke(8, 32'hFF1FF0EF);
    release_rst();
    clocks(3);
    chk("jal_fetch", {address, 2'b00}, 32'h10);
    clocks(3);
    chk("beq_fetch", {address, 2'b00}, 32'h18);
    clocks(3);
    chk("bne_fetch", {address, 2'b00}, 32'h1C);
    clocks(3);
    chk("addi_x5", dut.u_rf.regs_q[5], 32'd1);
    clocks(3);
    chk("jal_back", {address, 2'b00}, 32'h10);
    chk("jal_link", dut.u_rf.regs_q[1], 32'h24);

    // Misaligned LW halts, rd unchanged
    reset_clear();
    poke(0, 32'h10200093);
    poke(1, 32'h00900193);
    poke(2, 32'h0000A183);
    release_rst();
    clocks(20);
    chk("lw_mis_rd", dut.u_rf.regs_q[3], 32'd9);
    chk("lw_mis_addr", {2'b00, address}, 32'd2);
    clocks(10);
    chk("lw_halt_hold", {2'b00, address}, 32'd2);

    // EBREAK halts
    reset_clear();
    poke(0, 32'h00500093);
    poke(1, 32'h00100073);
    release_rst();
    clocks(20);
    chk("ebreak_addr", {2'b00, address}, 32'd1);
    chk("ebreak_x1", dut.u_rf.regs_q[1], 32'd5);

    // Store to non-writable region
    reset_clear();
    wcap_en = 1'b0;
    poke(64, 32'hDEADBEEF);
    poke(0, 32'h10000093);
    poke(1, 32'h05500113);
    poke(2, 32'h0020A023);
    we0 = we_cnt;
    release_rst();
    clocks(20);
    chk("sw_ro_we", we_cnt - we0, 32'd0);
    chk("sw_ro_mem", mem[64], 32'hDEADBEEF);
    chk("sw_ro_addr", {2'b00, address}, 32'd2);
    clocks(10);
    chk("sw_ro_hold", {2'b00, address}, 32'd2);

    // Async reset during a store's MEM cycle
    reset_clear();
    wcap_en = 1'b1;
    poke(64, 32'hCAFEF00D);
    poke(0, 32'h10000093);
    poke(1, 32'h07700113);
    poke(2, 32'h0020A023);
    release_rst();
    clocks(9);
    chk("mem_we_on", {31'd0, write_enable}, 32'd1);
    chk("mem_addr", {2'b00, address}, 32'h40);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", {31'd0, write_enable}, 32'd0);
    chk("arst_din", memory_in, 32'd0);
    chk("arst_addr", {2'b00, address}, 32'd0);
    clocks(2);
    chk("arst_mem", mem[64], 32'hCAFEF00D);
    release_rst();
    clocks(3);
    chk("restart_pc", dut.pc_q, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
